// File: rtl/axi_lab_pkg.sv
// Shared widths, FSM state type and constants for the lab AXI burst master.
package axi_lab_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned ID_W   = 4;

    localparam logic [DATA_W/8-1:0] STRB_ALL = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWdata,
        StRaddr,
        StRdata,
        StDone
    } state_e;

endpackage

// File: rtl/axi_burst_master_if.sv
// Lab AXI4-style bus: write/read address channels, write data channel and read data channel.
interface axi_burst_master_if;
    import axi_lab_pkg::*;

    logic [ADDR_W-1:0]   WR_ADDR;
    logic [LEN_W-1:0]    WR_LEN;
    logic [ID_W-1:0]     WR_ID;
    logic                WR_ADDR_VALID;
    logic                WR_ADDR_READY;
    logic [DATA_W-1:0]   WR_DATA;
    logic [DATA_W/8-1:0] WR_STRB;
    logic                WR_DATA_VALID;
    logic                WR_DATA_LAST;
    logic                WR_DATA_READY;
    logic [ID_W-1:0]     WR_BACK_ID;

    logic [ADDR_W-1:0]   RD_ADDR;
    logic [LEN_W-1:0]    RD_LEN;
    logic [ID_W-1:0]     RD_ID;
    logic                RD_ADDR_VALID;
    logic                RD_ADDR_READY;
    logic [DATA_W-1:0]   RD_DATA;
    logic [ID_W-1:0]     RD_BACK_ID;
    logic                RD_DATA_LAST;
    logic                RD_DATA_VALID;
    logic                RD_DATA_READY;

    modport master (
        output WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID,
        output WR_DATA, WR_STRB, WR_DATA_VALID, WR_DATA_LAST,
        output RD_ADDR, RD_LEN, RD_ID, RD_ADDR_VALID, RD_DATA_READY,
        input  WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID,
        input  RD_ADDR_READY, RD_DATA, RD_BACK_ID, RD_DATA_LAST, RD_DATA_VALID
    );

    modport slave (
        input  WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID,
        input  WR_DATA, WR_STRB, WR_DATA_VALID, WR_DATA_LAST,
        input  RD_ADDR, RD_LEN, RD_ID, RD_ADDR_VALID, RD_DATA_READY,
        output WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID,
        output RD_ADDR_READY, RD_DATA, RD_BACK_ID, RD_DATA_LAST, RD_DATA_VALID
    );

endinterface

// File: rtl/axi_watchdog.sv
// Stall watchdog: counts cycles without progress while active, flags expiry at TIMEOUT-1.
module axi_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic active,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!active || kick) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = active && (cnt_q == CNT_MAX);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI burst initiator: one read or write command at a time, data streamed
// through combinationally, with a watchdog that aborts stalled transfers.
module axi_burst_master
    import axi_lab_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              rdata_last,
    output logic              done,
    output logic              err,
    axi_burst_master_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [ID_W-1:0]   id_q;
    logic [LEN_W:0]    beat_q, beat_d;
    logic              err_q, err_d;

    logic aw_hs, w_hs, ar_hs, r_hs, any_hs, last_beat;
    logic wd_kick, wd_active, wd_expired;

    logic                wr_addr_valid, wr_data_valid, wr_data_last;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;
    logic                rd_addr_valid, rd_data_ready;

    assign aw_hs     = (state_q == StWaddr) && bus.WR_ADDR_READY;
    assign w_hs      = (state_q == StWdata) && wdata_valid && bus.WR_DATA_READY;
    assign ar_hs     = (state_q == StRaddr) && bus.RD_ADDR_READY;
    assign r_hs      = (state_q == StRdata) && bus.RD_DATA_VALID && rdata_ready;
    assign any_hs    = aw_hs || w_hs || ar_hs || r_hs;
    // 9-bit beat counter compared against zero-extended len so len=255 gives 256 beats
    assign last_beat = (beat_q == {1'b0, len_q});

    assign wd_active = (state_q == StWaddr) || (state_q == StWdata) ||
                       (state_q == StRaddr) || (state_q == StRdata);
    assign wd_kick   = any_hs || (state_d != state_q);

    axi_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .kick   (wd_kick),
        .active (wd_active),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
        end else if (state_q == StIdle && cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            id_q   <= cmd_id;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = cmd_write ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                if (aw_hs) begin
                    state_d = StWdata;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StWdata: begin
                if (w_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = StDone;
                        if (bus.WR_BACK_ID != id_q) err_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StRaddr: begin
                if (ar_hs) begin
                    state_d = StRdata;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StRdata: begin
                if (r_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (bus.RD_BACK_ID != id_q || bus.RD_DATA_LAST != last_beat) err_d = 1'b1;
                    // the beat count, not the responder's LAST, ends the burst
                    if (last_beat) state_d = StDone;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        done          = 1'b0;
        wdata_ready   = 1'b0;
        rdata_out     = '0;
        rdata_valid   = 1'b0;
        rdata_last    = 1'b0;
        wr_addr_valid = 1'b0;
        wr_data       = '0;
        wr_strb       = '0;
        wr_data_valid = 1'b0;
        wr_data_last  = 1'b0;
        rd_addr_valid = 1'b0;
        rd_data_ready = 1'b0;
        case (state_q)
            StIdle:  cmd_ready = 1'b1;
            StWaddr: wr_addr_valid = 1'b1;
            StWdata: begin
                wr_data_valid = wdata_valid;
                wdata_ready   = bus.WR_DATA_READY;
                wr_data       = wdata_in;
                wr_strb       = STRB_ALL;
                wr_data_last  = last_beat;
            end
            StRaddr: rd_addr_valid = 1'b1;
            StRdata: begin
                rdata_valid   = bus.RD_DATA_VALID;
                rd_data_ready = rdata_ready;
                rdata_out     = bus.RD_DATA;
                rdata_last    = last_beat;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign err = err_q;

    assign bus.WR_ADDR       = addr_q;
    assign bus.WR_LEN        = len_q;
    assign bus.WR_ID         = id_q;
    assign bus.WR_ADDR_VALID = wr_addr_valid;
    assign bus.WR_DATA       = wr_data;
    assign bus.WR_STRB       = wr_strb;
    assign bus.WR_DATA_VALID = wr_data_valid;
    assign bus.WR_DATA_LAST  = wr_data_last;
    assign bus.RD_ADDR       = addr_q;
    assign bus.RD_LEN        = len_q;
    assign bus.RD_ID         = id_q;
    assign bus.RD_ADDR_VALID = rd_addr_valid;
    assign bus.RD_DATA_READY = rd_data_ready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: bench-side slave memory, read responder and stall cases.
module tb_axi_burst_master;
    import axi_lab_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [31:0] wdata_in;
    logic        wdata_valid, wdata_ready;
    logic [31:0] rdata_out;
    logic        rdata_valid, rdata_ready, rdata_last;
    logic        done, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [512];

    always #5 clk = ~clk;

    axi_burst_master_if bus ();

    axi_burst_master #(
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_id     (cmd_id),
        .wdata_in   (wdata_in),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata_out  (rdata_out),
        .rdata_valid(rdata_valid),
        .rdata_ready(rdata_ready),
        .rdata_last (rdata_last),
        .done       (done),
        .err        (err),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wpat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Accept a command and run the address phase; slave READY comes after w waiting cycles.
    task automatic addr_phase(input logic wr, input logic [31:0] addr, input int len,
                              input logic [3:0] id, input int w, output logic [8:0] base);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = 8'(len);
        cmd_id    = id;
        if (wr) bus.WR_ADDR_READY = (w == 0);
        else    bus.RD_ADDR_READY = (w == 0);
        #1 chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        if (wr) begin
            chk("wr_avalid", 32'(bus.WR_ADDR_VALID), 32'd1);
            chk("wr_addr", bus.WR_ADDR, addr);
            chk("wr_len", 32'(bus.WR_LEN), 32'(len));
            chk("wr_id", 32'(bus.WR_ID), 32'(id));
        end else begin
            chk("rd_avalid", 32'(bus.RD_ADDR_VALID), 32'd1);
            chk("rd_addr", bus.RD_ADDR, addr);
            chk("rd_len", 32'(bus.RD_LEN), 32'(len));
            chk("rd_id", 32'(bus.RD_ID), 32'(id));
        end
        repeat (w) begin
            @(negedge clk);
            #1 chk("avalid_hold", 32'(wr ? bus.WR_ADDR_VALID : bus.RD_ADDR_VALID), 32'd1);
        end
        if (wr) bus.WR_ADDR_READY = 1'b1;
        else    bus.RD_ADDR_READY = 1'b1;
        base = addr[8:0];
        @(negedge clk);
        bus.WR_ADDR_READY = 1'b0;
        bus.RD_ADDR_READY = 1'b0;
        #1 chk("avalid_drop", 32'(bus.WR_ADDR_VALID | bus.RD_ADDR_VALID), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input int w, input int rst_beat);
        logic [8:0]  base;
        logic [31:0] d;
        bit          aborted = 1'b0;
        addr_phase(1'b1, addr, len, id, w, base);
        for (int i = 0; i <= len; i++) begin
            d               = wpat(addr + 32'(i));
            wdata_in        = d;
            wdata_valid     = 1'b1;
            bus.WR_DATA_READY = 1'b1;
            bus.WR_BACK_ID  = id;
            if (i == rst_beat) begin
                rst = 1'b0;
                #1;
                chk("rst_wvalid", 32'(bus.WR_DATA_VALID), 32'd0);
                chk("rst_wready", 32'(wdata_ready), 32'd0);
                chk("rst_wlast", 32'(bus.WR_DATA_LAST), 32'd0);
                chk("rst_wr_addr", bus.WR_ADDR, 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_err", 32'(err), 32'd0);
                wdata_valid       = 1'b0;
                bus.WR_DATA_READY = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                #1 chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
                aborted = 1'b1;
                break;
            end
            #1;
            chk("wr_dvalid", 32'(bus.WR_DATA_VALID), 32'd1);
            chk("wdata_ready", 32'(wdata_ready), 32'd1);
            chk("wr_data", bus.WR_DATA, d);
            chk("wr_strb", 32'(bus.WR_STRB), 32'hF);
            chk("wr_last", 32'(bus.WR_DATA_LAST), 32'(i == len));
            mem[base + 9'(i)] = bus.WR_DATA;
            @(negedge clk);
        end
        if (!aborted) begin
            wdata_valid       = 1'b0;
            bus.WR_DATA_READY = 1'b0;
            #1;
            chk("wr_done", 32'(done), 32'd1);
            chk("wr_err", 32'(err), 32'd0);
            chk("wr_dvalid_done", 32'(bus.WR_DATA_VALID), 32'd0);
            @(negedge clk);
            #1;
            chk("wr_done_pulse", 32'(done), 32'd0);
            chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    // Responder returns back_id on every beat and asserts LAST on the final beat and on 'early'.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int w, input bit toggle, input logic [3:0] back_id,
                           input int early, input bit exp_err);
        logic [8:0] base;
        int         i   = 0;
        int         cyc = 0;
        addr_phase(1'b0, addr, len, id, w, base);
        while (i <= len && cyc < 64) begin
            bus.RD_DATA_VALID = 1'b1;
            bus.RD_DATA       = mem[base + 9'(i)];
            bus.RD_BACK_ID    = back_id;
            bus.RD_DATA_LAST  = (i == len) || (i == early);
            rdata_ready       = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            chk("rd_dready_mirror", 32'(bus.RD_DATA_READY), 32'(rdata_ready));
            chk("rdata_valid", 32'(rdata_valid), 32'd1);
            if (rdata_ready) begin
                chk("rdata_out", rdata_out, mem[base + 9'(i)]);
                chk("rdata_last", 32'(rdata_last), 32'(i == len));
                i++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("rd_beats", 32'(i), 32'(len + 1));
        bus.RD_DATA_VALID = 1'b0;
        bus.RD_DATA_LAST  = 1'b0;
        rdata_ready       = 1'b0;
        #1;
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        #1;
        chk("rd_done_pulse", 32'(done), 32'd0);
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rd_err_sticky", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wdata_in = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
        bus.WR_ADDR_READY = 1'b0; bus.WR_DATA_READY = 1'b0; bus.WR_BACK_ID = '0;
        bus.RD_ADDR_READY = 1'b0; bus.RD_DATA = '0; bus.RD_BACK_ID = '0;
        bus.RD_DATA_LAST = 1'b0; bus.RD_DATA_VALID = 1'b0;
        for (int k = 0; k < 512; k++) mem[k] = 32'h5A00_0000 | 32'(k);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_wr_avalid", 32'(bus.WR_ADDR_VALID), 32'd0);
        chk("reset_rd_avalid", 32'(bus.RD_ADDR_VALID), 32'd0);
        chk("reset_wr_addr", bus.WR_ADDR, 32'd0);
        chk("reset_rd_len", 32'(bus.RD_LEN), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);

        do_write(32'h10, 3, 4'd5, 3, -1);
        for (int k = 0; k < 4; k++)
            chk("mem_after_write", mem[9'(16 + k)], wpat(32'(16 + k)));

        do_read(32'h10, 3, 4'd5, 0, 1'b0, 4'd5, -1, 1'b0);
        do_read(32'h10, 7, 4'd9, 2, 1'b1, 4'd9, -1, 1'b0);
        do_read(32'h10, 3, 4'd6, 1, 1'b0, 4'd2, -1, 1'b1);
        do_read(32'h20, 1, 4'd3, 0, 1'b0, 4'd3, -1, 1'b0);
        do_read(32'h10, 3, 4'd4, 0, 1'b0, 4'd4, 1, 1'b1);

        // Address channel never ready: watchdog must abort after 16 cycles of VALID
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_len = 8'd0; cmd_id = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (bus.WR_ADDR_VALID && n < 40) begin
            n++;
            @(negedge clk);
        end
        #1;
        chk("to_valid_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(err), 32'd1);
        chk("to_done", 32'(done), 32'd1);
        chk("to_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("to_done_pulse", 32'(done), 32'd0);
        chk("to_err_sticky", 32'(err), 32'd1);

        do_write(32'h100, 255, 4'd3, 0, -1);
        chk("mem_burst_first", mem[9'h100], wpat(32'h100));
        chk("mem_burst_last", mem[9'h1FF], wpat(32'h1FF));

        do_write(32'h100, 255, 4'd7, 1, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Single-outstanding burst initiator for the lab's AXI4-style bus (WR_*/RD_* channel naming, 32-bit data, 8-bit LEN, 4-bit ID, word-indexed addressing). It accepts one read or write command at a time from a local controller, drives the address and data channels toward a slave such as the memory model or a bus peripheral, and streams write data in and read data out. A watchdog aborts stalled transfers.

## Interface
- TIMEOUT, 1024: idle cycles without any handshake before a transfer is aborted (≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  start word address.
- cmd_len  in  8  beats − 1.
- cmd_id  in  4  transaction ID.
- wdata_in / wdata_valid / wdata_ready  in/in/out  32/1/1  write-data stream.
- rdata_out / rdata_valid / rdata_ready  out/out/in  32/1/1  read-data stream.
- rdata_last  out  1  final read beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error; cleared on the next accepted command.
- WR_ADDR, WR_LEN, WR_ID, WR_ADDR_VALID  out  32/8/4/1;  WR_ADDR_READY  in  1.
- WR_DATA, WR_STRB, WR_DATA_VALID, WR_DATA_LAST  out  32/4/1/1;  WR_DATA_READY  in  1;  WR_BACK_ID  in  4.
- RD_ADDR, RD_LEN, RD_ID, RD_ADDR_VALID  out  32/8/4/1;  RD_ADDR_READY  in  1.
- RD_DATA, RD_BACK_ID, RD_DATA_LAST, RD_DATA_VALID  in  32/4/1/1;  RD_DATA_READY  out  1.

## Operation
- FSM states are IDLE, WADDR, WDATA, RADDR, RDATA, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/id, clear err and beat_cnt, then go to WADDR or RADDR.
- WADDR/RADDR: the matching *_ADDR_VALID=1 with registered addr/len/id held stable. On VALID&&READY, go to WDATA/RDATA.
- WDATA: combinational pass-through.
  - WR_DATA_VALID = wdata_valid; wdata_ready = WR_DATA_READY; WR_DATA = wdata_in; WR_STRB = 4'hF.
  - WR_DATA_LAST = (beat_cnt == len).
  - Each beat handshake increments beat_cnt. The handshake with LAST goes to DONE.
  - If WR_BACK_ID ≠ id on that handshake, set err.
- RDATA: pass-through.
  - rdata_valid = RD_DATA_VALID; RD_DATA_READY = rdata_ready; rdata_out = RD_DATA; rdata_last = (beat_cnt == len).
  - Every handshake checks that RD_BACK_ID == id and that RD_DATA_LAST == (beat_cnt == len). Any mismatch sets err.
  - The handshake at beat_cnt == len goes to DONE, whether or not RD_DATA_LAST was asserted.
- DONE: done=1 for one cycle, then IDLE.
- Watchdog: a counter resets on any handshake and on state entry, and increments otherwise in WADDR/WDATA/RADDR/RDATA. When it reaches TIMEOUT−1: set err, deassert all VALID/READY outputs next cycle, go to DONE.
- Outside their owning state, all bus VALID/READY outputs and wdata_ready/rdata_valid are 0.
- beat_cnt is 9 bits, so len = 255 yields 256 beats with no overflow. The address is not incremented by the master; the slave owns burst addressing.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; all registered outputs 0, including WR_ADDR, WR_LEN, WR_ID, RD_* address fields, done and err. cmd_ready=1 from the first cycle after release.
- Command accepted at edge N → *_ADDR_VALID high from N+1.
- Address handshake at edge M → data phase from M+1. Data beats pass through with zero latency, so full throughput is 1 beat/cycle.
- Last-beat handshake at edge K → done=1 during K+1 → cmd_ready=1 at K+2. Minimum turnaround is 2 cycles.
- A slave READY that is already high when VALID rises completes the handshake in that cycle.
- Reset mid-burst drops all VALIDs immediately (asynchronous).
- cmd_valid during non-IDLE states is ignored (cmd_ready=0).

## Structure
- A package axi_lab_pkg holds:
  - localparams for ADDR_W=32, DATA_W=32, LEN_W=8, ID_W=4;
  - the state enum typedef;
  - STRB_ALL = 4'hF.
- A sub-module axi_watchdog (counter, kick, active, expired) holds the timeout logic, parameterised by TIMEOUT. Everything else lives in one FSM module.

## Test plan
- Write cmd addr=0x10, len=3, id=5 against the slave model with READY after 3 cycles → 4 beats accepted, LAST on 4th, done 1 cycle later, err=0; the model holds 0x10..0x13 as written.
- Read-back of the same range, rdata_ready always 1 → rdata_out matches, rdata_last on beat 4, RD_DATA_READY high throughout RDATA, err=0.
- Read len=7 with rdata_ready toggling every other cycle → exactly 8 beats, none dropped or duplicated, RD_DATA_READY mirrors rdata_ready.
- Read where the responder returns RD_BACK_ID=2 for id=6, or asserts LAST on beat 2 of 4 → err=1 and held; the next cmd clears it.
- WR_ADDR_READY held 0, TIMEOUT=16 → err=1 and WR_ADDR_VALID drops 16 cycles after assertion; done pulses; cmd_ready=1 two cycles later.
- len=255 write → 256 beats, LAST only on beat 256; reset asserted at beat 100 → all outputs 0 asynchronously, IDLE after release.
